snn_bitserial_integrator: RTL and testbench

Bit-serial integrate-and-fire membrane accumulator that drives the team's transmission-gate full-adder cell. It accepts a signed synaptic weight per handshake and adds it to the membrane potential one bit per clock, LSB first. The block presents operand bits on `fa_a`/`fa_b`/`fa_c` and captures `fa_sum`/`fa_carry`, so it sits directly upstream and downstream of the full adder. It then saturates the result, compares it against threshold, and emits a spike.

---
 rtl/neuron_pkg.sv | 18 +
 rtl/piso_shreg.sv | 24 ++
 rtl/snn_bitserial_integrator.sv | 165 ++++++++++++++++
 tb/tb_snn_bitserial_integrator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared neuron types: accumulator FSM states and two's-complement saturation bounds.
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    CHECK = 2'd2
  } nrn_state_e;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, right-shift register with serial-in at the MSB; LSB is the serial output.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[W-1:1]};
    end
  end

endmodule

// File: rtl/snn_bitserial_integrator.sv
// Bit-serial integrate-and-fire accumulator: streams V + weight LSB-first through an
// external full-adder cell, saturates the result and fires against a threshold.
module snn_bitserial_integrator
  import neuron_pkg::*;
#(
  parameter int W      = 8,
  parameter int THRESH = 64,
  parameter int V_REST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_weight,
  input  logic         clr,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_c,
  input  logic         fa_sum,
  input  logic         fa_carry,
  output logic [W-1:0] v_out,
  output logic         spike,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  nrn_state_e state, next_state;

  logic [CW-1:0]       cnt;
  logic                carry_q;
  logic                c_msb;
  logic                w_msb;
  logic signed [W-1:0] v_q;
  logic                spike_q;
  logic                ld;
  logic                sh;
  logic                last_bit;
  logic [W-1:0]        sum_q;
  logic [W-1:0]        wt_q;
  logic signed [W-1:0] r;
  logic                fire;
  logic                unused_wt;

  function automatic logic signed [W-1:0] saturate(input logic ovf, input logic neg,
                                                   input logic signed [W-1:0] s);
    if (!ovf)
      return s;
    else if (neg)
      return $signed(W'(sat_min(W)));
    else
      return $signed(W'(sat_max(W)));
  endfunction

  // Only the weight LSB feeds the adder; the upper bits are just the shift path.
  assign unused_wt = ^wt_q[W-1:1];

  assign last_bit = (cnt == CW'(W - 1));

  piso_shreg #(.W(W)) u_wt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ld),
    .din  (in_weight),
    .shift(sh),
    .sin  (1'b0),
    .q    (wt_q)
  );

  piso_shreg #(.W(W)) u_sum (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ld),
    .din  (v_q),
    .shift(sh),
    .sin  (fa_sum),
    .q    (sum_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && !clr) next_state = ADD;
      ADD:     if (last_bit) next_state = CHECK;
      CHECK:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    ld       = 1'b0;
    sh       = 1'b0;
    fa_a     = 1'b0;
    fa_b     = 1'b0;
    fa_c     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = !clr;
        ld       = in_valid && !clr;
      end
      ADD: begin
        sh   = 1'b1;
        fa_a = sum_q[0];
        fa_b = wt_q[0];
        fa_c = (cnt == '0) ? 1'b0 : carry_q;
      end
      default: ;
    endcase
  end

  // Overflow: carry into the MSB differs from carry out of it; the operands shared a sign.
  assign r    = saturate(c_msb ^ carry_q, w_msb, $signed(sum_q));
  assign fire = (r >= $signed(W'(THRESH)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      c_msb   <= 1'b0;
      w_msb   <= 1'b0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      spike_q <= 1'b0;
      case (state)
        IDLE: begin
          if (clr) begin
            v_q <= '0;
          end else if (in_valid) begin
            cnt     <= '0;
            carry_q <= 1'b0;
            w_msb   <= in_weight[W-1];
          end
        end
        ADD: begin
          cnt     <= cnt + 1'b1;
          carry_q <= fa_carry;
          if (last_bit) c_msb <= fa_c;
        end
        CHECK: begin
          if (fire) begin
            v_q     <= $signed(W'(V_REST));
            spike_q <= 1'b1;
          end else begin
            v_q <= r;
          end
        end
        default: ;
      endcase
    end
  end

  assign v_out = v_q;
  assign spike = spike_q;

endmodule

// File: tb/tb_snn_bitserial_integrator.sv
// Bench for snn_bitserial_integrator with an ideal full-adder model closing the loop.
module tb_snn_bitserial_integrator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_weight = '0;
  logic         clr = 1'b0;
  logic         fa_a, fa_b, fa_c;
  logic         fa_sum, fa_carry;
  logic [W-1:0] v_out;
  logic         spike;
  logic         busy;

  assign fa_sum   = fa_a ^ fa_b ^ fa_c;
  assign fa_carry = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

  snn_bitserial_integrator #(.W(W), .THRESH(64), .V_REST(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_weight(in_weight),
    .clr      (clr),
    .fa_a     (fa_a),
    .fa_b     (fa_b),
    .fa_c     (fa_c),
    .fa_sum   (fa_sum),
    .fa_carry (fa_carry),
    .v_out    (v_out),
    .spike    (spike),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int exp_v;
    int exp_s;
    bit trace;
  } vec_t;

  typedef struct {
    int v;
    int s;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   vm = 0;
  bit   mon_en = 1'b1;
  logic busy_d = 1'b0;
  exp_t sbq[$];
  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int w, output int ev, output int es);
    int s;
    s = vm + w;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (s >= 64) begin
      ev = 0;
      es = 1;
    end else begin
      ev = s;
      es = 0;
    end
    vm = ev;
  endfunction

  // Result monitor: the cycle busy drops is the first cycle v_out/spike carry the result.
  always @(negedge clk) begin
    if (mon_en && busy_d && !busy) begin
      if (sbq.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("v_out", $signed(v_out), e.v);
        check("spike", int'(spike), e.s);
      end
    end
    busy_d <= busy;
  end

  task automatic send(input int w, input int ev, input int es, input bit trace);
    int           n;
    logic [W-1:0] wv;
    wv = w[W-1:0];
    @(negedge clk);
    in_valid  = 1'b1;
    in_weight = wv;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sbq.push_back('{ev, es});
    #1;
    in_valid  = 1'b0;
    in_weight = W'($urandom);
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      check("in_ready_low", int'(in_ready), 0);
      if (trace && i < W) begin
        check("fa_b_bit", int'(fa_b), int'(wv[i]));
        if (i == 0) check("fa_c_bit0", int'(fa_c), 0);
      end
    end
    @(negedge clk);
    check("in_ready_return", int'(in_ready), 1);
    @(negedge clk);
    check("spike_one_cycle", int'(spike), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev, es, w, sp;

    vecs[0]  = '{20, 20, 0, 0};
    vecs[1]  = '{20, 40, 0, 0};
    vecs[2]  = '{20, 60, 0, 0};
    vecs[3]  = '{10, 0, 1, 0};
    vecs[4]  = '{-5, -5, 0, 1};
    vecs[5]  = '{65, 60, 0, 0};
    vecs[6]  = '{100, 0, 1, 0};
    vecs[7]  = '{-100, -100, 0, 0};
    vecs[8]  = '{-100, -128, 0, 0};
    vecs[9]  = '{30, -98, 0, 0};
    vecs[10] = '{127, 29, 0, 0};
    vecs[11] = '{40, 0, 1, 0};

    #12;
    check("rst_v_out", int'(v_out), 0);
    check("rst_spike", int'(spike), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_fa", int'({fa_a, fa_b, fa_c}), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) send(vecs[i].w, vecs[i].exp_v, vecs[i].exp_s, vecs[i].trace);
    vm = 0;

    // clr beats in_valid in IDLE and the weight is dropped
    send(40, 40, 0, 0);
    vm = 40;
    @(negedge clk);
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_weight = 8'd5;
    #1;
    check("clr_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check("clr_v_out", int'(v_out), 0);
    check("clr_busy", int'(busy), 0);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    vm = 0;
    model(20, ev, es);
    send(20, ev, es, 0);

    // Asynchronous reset during ADD bit 3 discards the partial sum
    mon_en = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_weight = 8'd50;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_v_out", int'(v_out), 0);
    check("mid_rst_spike", int'(spike), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_fa", int'({fa_a, fa_b, fa_c}), 0);
    check("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    sp = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      sp = sp | int'(spike);
    end
    check("no_spike_after_rst", sp, 0);
    check("v_out_after_rst", int'(v_out), 0);
    mon_en = 1'b1;
    vm = 0;

    for (int k = 0; k < 8; k++) begin
      w = int'($urandom_range(0, 255)) - 128;
      model(w, ev, es);
      send(w, ev, es, 0);
    end

    check("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
